stack_param: RTL and testbench

STACK_PARAM -- requirements
Module: stack_param

---
 rtl/stack_pkg.sv | 18 +
 rtl/stack_if.sv | 36 +++
 rtl/stack_mem.sv | 32 +++
 rtl/stack_param.sv | 140 ++++++++++++++
 tb/tb_stack_param.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// stack_pkg -- shared types and helpers for the stack_param block.
//   op_e  : the per-edge operation decoded from {Pop, Push}
//   ptr_w : index width needed to address DEPTH entries
package stack_pkg;

  // Encoding matches {Pop, Push}, so the decode is a plain cast.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_if.sv
// stack_if -- request/response bundle of the stack.
//   Data_In, Push, Pop            : driven by the master (user of the stack)
//   Data_Out, Data_Valid, Top,
//   Count, Full, Empty,
//   Overflow, Underflow           : driven by the slave (stack_param)
// Count is ptr_w(DEPTH)+1 bits wide so that it can hold the value DEPTH.
interface stack_if
  import stack_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
);
  localparam int CW = ptr_w(DEPTH) + 1;

  logic [DATA_W-1:0] Data_In;
  logic              Push;
  logic              Pop;
  logic [DATA_W-1:0] Data_Out;
  logic              Data_Valid;
  logic [DATA_W-1:0] Top;
  logic [CW-1:0]     Count;
  logic              Full;
  logic              Empty;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output Data_In, Push, Pop,
    input  Data_Out, Data_Valid, Top, Count, Full, Empty, Overflow, Underflow
  );

  modport slave (
    input  Data_In, Push, Pop,
    output Data_Out, Data_Valid, Top, Count, Full, Empty, Overflow, Underflow
  );
endinterface

// File: rtl/stack_mem.sv
// stack_mem -- DEPTH x DATA_W register array for the stack.
//   i_clk   : clock, write happens on rising edge
//   i_we    : write enable
//   i_waddr : write index
//   i_wdata : write data
//   i_raddr : read index
//   o_rdata : asynchronous read data
// Contents are never reset; only occupied entries are ever observed.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int AW     = ptr_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_param.sv
// stack_param -- parameterised LIFO stack with push/pop/swap.
//   Clk  : clock, all state changes on rising edge
//   RstN : synchronous active-low reset
//   bus  : stack_if.slave -- Data_In/Push/Pop in; Data_Out (registered),
//          Data_Valid (1-cycle pulse), Top (combinational peek, 0 when empty),
//          Count, Full, Empty, Overflow, Underflow out.
// Optional build macro STACK_ERR_FLAGS_EN: enables the sticky Overflow /
// Underflow error registers; without it both ports are constant 0.
module stack_param
  import stack_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8
) (
  input logic   Clk,
  input logic   RstN,
  stack_if.slave bus
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  op_e               w_op;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_top_cnt;
  logic [AW-1:0]     w_top_idx;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [DATA_W-1:0] w_rdata;

  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_dout;
  logic              r_dvalid;

  assign w_op    = op_e'({bus.Pop, bus.Push});
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Index of the top entry; only meaningful when not empty. At Count==DEPTH
  // the truncation to AW bits still lands on DEPTH-1.
  assign w_top_cnt = r_count - CW'(1);
  assign w_top_idx = w_top_cnt[AW-1:0];

  // Push writes the slot just above the top; swap overwrites the top itself.
  // Writes are suppressed while reset is asserted so reset always wins.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_top_idx;
    if (RstN) begin
      case (w_op)
        OP_PUSH: begin
          w_we    = !w_full;
          w_waddr = r_count[AW-1:0];
        end
        OP_SWAP: begin
          w_we    = !w_empty;
          w_waddr = w_top_idx;
        end
        default: begin
          w_we    = 1'b0;
          w_waddr = w_top_idx;
        end
      endcase
    end
  end

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (bus.Data_In),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_count  <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      case (w_op)
        OP_PUSH: begin
          if (!w_full) r_count <= r_count + CW'(1);
        end
        OP_POP: begin
          if (!w_empty) begin
            r_dout   <= w_rdata;
            r_dvalid <= 1'b1;
            r_count  <= w_top_cnt;
          end
        end
        OP_SWAP: begin
          // On an empty stack the incoming word goes straight to the output.
          r_dout   <= w_empty ? bus.Data_In : w_rdata;
          r_dvalid <= 1'b1;
        end
        default: begin
          r_dvalid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_op == OP_PUSH && w_full)  r_ovf <= 1'b1;
      if (w_op == OP_POP  && w_empty) r_unf <= 1'b1;
    end
  end

  assign bus.Overflow  = r_ovf;
  assign bus.Underflow = r_unf;
`else
  assign bus.Overflow  = 1'b0;
  assign bus.Underflow = 1'b0;
`endif

  assign bus.Data_Out   = r_dout;
  assign bus.Data_Valid = r_dvalid;
  assign bus.Top        = w_empty ? '0 : w_rdata;
  assign bus.Count      = r_count;
  assign bus.Full       = w_full;
  assign bus.Empty      = w_empty;

endmodule

// File: tb/tb_stack_param.sv
// tb_stack_param -- directed bench for stack_param (DATA_W=4, DEPTH=8).
// Expected flag values follow the STACK_ERR_FLAGS_EN build macro.
`timescale 1ns/1ps
module tb_stack_param;
  import stack_pkg::*;

`ifdef STACK_ERR_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  logic Clk  = 1'b0;
  logic RstN = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  stack_if #(.DATA_W(4), .DEPTH(8)) bus ();

  stack_param #(.DATA_W(4), .DEPTH(8)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One edge with the given request; outputs are sampled 1ns after the edge.
  task automatic op(input logic push, input logic pop, input logic [3:0] din);
    bus.Push    = push;
    bus.Pop     = pop;
    bus.Data_In = din;
    @(posedge Clk);
    #1;
    bus.Push    = 1'b0;
    bus.Pop     = 1'b0;
  endtask

  task automatic do_reset();
    RstN = 1'b0;
    op(1'b0, 1'b0, 4'd0);
    RstN = 1'b1;
  endtask

  initial begin
    bus.Push    = 1'b0;
    bus.Pop     = 1'b0;
    bus.Data_In = '0;
    do_reset();

    // reset state
    chk("rst_count", bus.Count, 0);
    chk("rst_empty", bus.Empty, 1);
    chk("rst_full",  bus.Full, 0);
    chk("rst_dout",  bus.Data_Out, 0);
    chk("rst_dvld",  bus.Data_Valid, 0);
    chk("rst_top",   bus.Top, 0);
    chk("rst_ovf",   bus.Overflow, 0);
    chk("rst_unf",   bus.Underflow, 0);

    // two pops on empty
    for (int i = 0; i < 2; i++) begin
      op(1'b0, 1'b1, 4'd0);
      chk("upop_dvld",  bus.Data_Valid, 0);
      chk("upop_dout",  bus.Data_Out, 0);
      chk("upop_count", bus.Count, 0);
      chk("upop_empty", bus.Empty, 1);
    end
    chk("upop_unf", bus.Underflow, FLG);

    // fill 1..8, then overfill with 9..15
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 1'b0, 4'(i));
      chk("push_count", bus.Count, i);
      chk("push_top",   bus.Top, i);
      chk("push_dvld",  bus.Data_Valid, 0);
    end
    chk("fill_full", bus.Full, 1);
    for (int i = 9; i <= 15; i++) begin
      op(1'b1, 1'b0, 4'(i));
      chk("ovf_count", bus.Count, 8);
      chk("ovf_top",   bus.Top, 8);
      chk("ovf_dvld",  bus.Data_Valid, 0);
    end
    chk("ovf_full", bus.Full, 1);
    chk("ovf_flag", bus.Overflow, FLG);
    chk("ovf_unf",  bus.Underflow, 0);

    // drain: 8,7,...,1
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 1'b1, 4'd0);
      chk("drain_dout",  bus.Data_Out, 8 - i);
      chk("drain_dvld",  bus.Data_Valid, 1);
      chk("drain_count", bus.Count, 7 - i);
    end
    op(1'b0, 1'b0, 4'd0);
    chk("idle_dvld",  bus.Data_Valid, 0);
    chk("idle_dout",  bus.Data_Out, 1);
    chk("drain_empty", bus.Empty, 1);
    chk("drain_top",   bus.Top, 0);
    chk("drain_ovf",   bus.Overflow, FLG);

    // interleaved push/pop
    op(1'b1, 1'b0, 4'd5);
    op(1'b1, 1'b0, 4'd5);
    op(1'b0, 1'b1, 4'd0);
    chk("mix_dout1", bus.Data_Out, 5);
    op(1'b1, 1'b0, 4'd7);
    chk("mix_dvld0", bus.Data_Valid, 0);
    op(1'b0, 1'b1, 4'd0);
    chk("mix_dout2", bus.Data_Out, 7);
    op(1'b0, 1'b1, 4'd0);
    chk("mix_dout3", bus.Data_Out, 5);
    chk("mix_count", bus.Count, 0);

    // swap on non-empty, then on empty
    op(1'b1, 1'b0, 4'd3);
    op(1'b1, 1'b1, 4'd9);
    chk("swap_dout",  bus.Data_Out, 3);
    chk("swap_dvld",  bus.Data_Valid, 1);
    chk("swap_top",   bus.Top, 9);
    chk("swap_count", bus.Count, 1);
    op(1'b0, 1'b1, 4'd0);
    chk("swap_pop",   bus.Data_Out, 9);
    op(1'b1, 1'b1, 4'd6);
    chk("eswap_dout",  bus.Data_Out, 6);
    chk("eswap_dvld",  bus.Data_Valid, 1);
    chk("eswap_count", bus.Count, 0);
    chk("eswap_top",   bus.Top, 0);
    chk("eswap_unf",   bus.Underflow, 0);

    // swap on a full stack keeps Count at DEPTH
    do_reset();
    for (int i = 1; i <= 8; i++) op(1'b1, 1'b0, 4'(i + 2));
    op(1'b1, 1'b1, 4'd1);
    chk("fswap_dout",  bus.Data_Out, 10);
    chk("fswap_top",   bus.Top, 1);
    chk("fswap_count", bus.Count, 8);
    chk("fswap_ovf",   bus.Overflow, 0);

    // reset mid-sequence at Count=4 with Push held high
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 4'(i + 10));
    op(1'b0, 1'b1, 4'd0);
    chk("pre_count", bus.Count, 4);
    chk("pre_dvld",  bus.Data_Valid, 1);
    RstN = 1'b0;
    op(1'b1, 1'b0, 4'd2);
    RstN = 1'b1;
    chk("mrst_count", bus.Count, 0);
    chk("mrst_dvld",  bus.Data_Valid, 0);
    chk("mrst_dout",  bus.Data_Out, 0);
    chk("mrst_ovf",   bus.Overflow, 0);
    chk("mrst_unf",   bus.Underflow, 0);
    op(1'b1, 1'b0, 4'd2);
    chk("post_count", bus.Count, 1);
    chk("post_top",   bus.Top, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
